// File: rtl/multibyte_compare_ctrl.sv
// Multi-byte magnitude comparator controller.
// Fetches operand byte pairs MSB-first (index len-1 down to 0) and stops at
// the first differing pair. In signed mode only the most significant byte
// carries the sign, so only that byte has its top bit inverted before the
// compare.
module multibyte_compare_ctrl #(
   parameter  int BYTE_WIDTH = 8,
   parameter  int MAX_BYTES  = 4,
   localparam int IW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
   localparam int LW         = $clog2(MAX_BYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [LW-1:0]         len,
   input  logic                  signed_mode,
   output logic                  rd_req,
   output logic [IW-1:0]         rd_idx,
   input  logic                  rd_valid,
   input  logic [BYTE_WIDTH-1:0] rd_a,
   input  logic [BYTE_WIDTH-1:0] rd_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_equal,
   output logic                  res_a_larger,
   output logic [BYTE_WIDTH-1:0] res_diff,
   output logic [LW-1:0]         res_bytes_used
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

   state_t                r_state, w_next;
   logic [LW-1:0]         r_len;
   logic                  r_signed;
   logic [IW-1:0]         r_idx;
   logic                  r_equal, r_a_larger;
   logic [BYTE_WIDTH-1:0] r_diff;
   logic [LW-1:0]         r_used;

   logic                  w_start, w_accept, w_neq, w_last, w_flip, w_gt;
   logic [LW-1:0]         w_len_c;
   logic [BYTE_WIDTH-1:0] w_a_cmp, w_b_cmp;

   assign w_start  = start_valid & (r_state == S_IDLE);
   assign w_len_c  = (len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : len;
   // rd_valid only counts while a fetch is outstanding
   assign w_accept = (r_state == S_FETCH) & rd_valid;
   assign w_neq    = (rd_a != rd_b);
   assign w_last   = (r_idx == '0);
   // sign bit lives only in the most significant byte
   assign w_flip   = r_signed & (LW'(r_idx) == (r_len - 1'b1));

   // bias the sign bit so a plain unsigned compare orders two's complement
   always_comb begin
      w_a_cmp = rd_a;
      w_b_cmp = rd_b;
      w_a_cmp[BYTE_WIDTH-1] = rd_a[BYTE_WIDTH-1] ^ w_flip;
      w_b_cmp[BYTE_WIDTH-1] = rd_b[BYTE_WIDTH-1] ^ w_flip;
   end

   assign w_gt = (w_a_cmp > w_b_cmp);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = (w_len_c == '0) ? S_DONE : S_FETCH;
         S_FETCH: if (w_accept && (w_neq || w_last)) w_next = S_DONE;
         S_DONE:  if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // operation context, byte index walk and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len      <= '0;
         r_signed   <= 1'b0;
         r_idx      <= '0;
         r_equal    <= 1'b0;
         r_a_larger <= 1'b0;
         r_diff     <= '0;
         r_used     <= '0;
      end else if (w_start) begin
         r_len      <= w_len_c;
         r_signed   <= signed_mode;
         r_idx      <= (w_len_c == '0) ? '0 : IW'(w_len_c - 1'b1);
         // a zero-length operand is trivially equal with nothing consumed
         r_equal    <= (w_len_c == '0);
         r_a_larger <= 1'b0;
         r_diff     <= '0;
         r_used     <= '0;
      end else if (w_accept) begin
         if (w_neq) begin
            r_equal    <= 1'b0;
            r_a_larger <= w_gt;
            r_diff     <= rd_a ^ rd_b;
            r_used     <= r_len - LW'(r_idx);
         end else if (w_last) begin
            r_equal    <= 1'b1;
            r_a_larger <= 1'b0;
            r_diff     <= '0;
            r_used     <= r_len;
         end else begin
            r_idx <= r_idx - 1'b1;
         end
      end
   end

   assign start_ready    = (r_state == S_IDLE);
   assign rd_req         = (r_state == S_FETCH);
   assign rd_idx         = r_idx;
   assign res_valid      = (r_state == S_DONE);
   assign res_equal      = r_equal;
   assign res_a_larger   = r_a_larger;
   assign res_diff       = r_diff;
   assign res_bytes_used = r_used;

endmodule

// File: tb/tb_multibyte_compare_ctrl.sv
// Bench for multibyte_compare_ctrl: directed vector table, hand sequences
// for reset and result back-pressure, and randomized ops against a model.
module tb_multibyte_compare_ctrl;

   localparam int BW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_valid, start_ready;
   logic [2:0]    len;
   logic          signed_mode;
   logic          rd_req;
   logic [1:0]    rd_idx;
   logic          rd_valid;
   logic [BW-1:0] rd_a, rd_b;
   logic          res_valid, res_ready;
   logic          res_equal, res_a_larger;
   logic [BW-1:0] res_diff;
   logic [2:0]    res_bytes_used;

   int total = 0;
   int bad   = 0;

   multibyte_compare_ctrl #(.BYTE_WIDTH(BW), .MAX_BYTES(MB)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .len(len), .signed_mode(signed_mode),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
      .rd_a(rd_a), .rd_b(rd_b),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_equal(res_equal), .res_a_larger(res_a_larger),
      .res_diff(res_diff), .res_bytes_used(res_bytes_used)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          len;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      int          gap;
      bit          eq;
      bit          gt;
      int          diff;
      int          used;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: operands as integers, sign only on the top byte, first
   // differing byte from the top decides.
   function automatic void model(input int l, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b, output bit eq, output bit gt,
                                 output int diff, output int used);
      int n = (l > MB) ? MB : l;
      eq = 1'b1; gt = 1'b0; diff = 0; used = 0;
      for (int i = n - 1; i >= 0; i--) begin
         int av = int'(a[i*8 +: 8]);
         int bv = int'(b[i*8 +: 8]);
         used++;
         if (sgn && i == n - 1) begin
            if (av >= 128) av -= 256;
            if (bv >= 128) bv -= 256;
         end
         if (av != bv) begin
            eq = 1'b0;
            gt = (av > bv);
            diff = int'(a[i*8 +: 8] ^ b[i*8 +: 8]);
            return;
         end
      end
   endfunction

   // One complete operation: start, serve fetches with 'gap' idle cycles
   // before each byte, hold the result 'hold' cycles, optionally poke
   // start_valid while busy, then release.
   task automatic run_op(input string tag, input int l, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input int gap, input int hold, input bit poke,
                         input bit eq, input bit gt, input int diff, input int used);
      int q[$];
      int cyc = 0;
      int wcnt = 0;
      int prev = -1;
      int n = (l > MB) ? MB : l;
      @(negedge clk);
      chk({tag, ".ready"}, int'(start_ready), 1);
      start_valid = 1'b1; len = 3'(l); signed_mode = sgn;
      @(negedge clk);
      start_valid = 1'b0;
      while (!res_valid && cyc < 200) begin
         rd_valid = 1'b0;
         if (rd_req) begin
            if (int'(rd_idx) != prev) begin
               q.push_back(int'(rd_idx));
               prev = int'(rd_idx);
               wcnt = 0;
            end
            if (wcnt >= gap) begin
               rd_valid = 1'b1;
               rd_a = a[rd_idx*8 +: 8];
               rd_b = b[rd_idx*8 +: 8];
               prev = -1;
            end else begin
               wcnt++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      rd_valid = 1'b0;
      chk({tag, ".latency"}, cyc, used * (gap + 1));
      chk({tag, ".nfetch"}, q.size(), used);
      foreach (q[k]) chk($sformatf("%s.idx%0d", tag, k), q[k], n - 1 - k);
      for (int h = 0; h <= hold; h++) begin
         chk({tag, ".valid"}, int'(res_valid), 1);
         chk({tag, ".eq"}, int'(res_equal), int'(eq));
         chk({tag, ".gt"}, int'(res_a_larger), int'(gt));
         chk({tag, ".diff"}, int'(res_diff), diff);
         chk({tag, ".used"}, int'(res_bytes_used), used);
         chk({tag, ".busy"}, int'(start_ready), 0);
         start_valid = poke && (h == 0);
         len = 3'd2;
         if (h == hold) res_ready = 1'b1;
         @(negedge clk);
      end
      start_valid = 1'b0;
      res_ready = 1'b0;
      chk({tag, ".released"}, int'(res_valid), 0);
      chk({tag, ".idle"}, int'(start_ready), 1);
      if (poke) begin
         @(negedge clk);
         chk({tag, ".noqueue"}, int'(rd_req), 0);
      end
   endtask

   initial begin
      bit    m_eq, m_gt;
      int    m_diff, m_used;
      vec_t  v;

      vecs[0] = '{2, 0, 32'h0000_1234, 32'h0000_1230, 0, 0, 1, 'h04, 2};
      vecs[1] = '{4, 0, 32'h0155_5555, 32'h0255_5555, 0, 0, 0, 'h03, 1};
      vecs[2] = '{1, 1, 32'h0000_0080, 32'h0000_007F, 0, 0, 0, 'hFF, 1};
      vecs[3] = '{1, 0, 32'h0000_0080, 32'h0000_007F, 0, 0, 1, 'hFF, 1};
      vecs[4] = '{3, 0, 32'h00AA_AAAA, 32'h00AA_AAAA, 2, 1, 0, 0, 3};
      vecs[5] = '{0, 0, 32'h1234_5678, 32'h8765_4321, 0, 1, 0, 0, 0};
      vecs[6] = '{7, 0, 32'h1122_3344, 32'h1122_3344, 0, 1, 0, 0, 4};
      vecs[7] = '{2, 1, 32'h0000_05F0, 32'h0000_0510, 1, 0, 1, 'hE0, 2};
      vecs[8] = '{4, 1, 32'hFF00_0000, 32'h0100_0000, 0, 0, 0, 'hFE, 1};

      rst = 1'b1; start_valid = 1'b0; len = '0; signed_mode = 1'b0;
      rd_valid = 1'b0; rd_a = '0; rd_b = '0; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.rd_req", int'(rd_req), 0);
      chk("rst.rd_idx", int'(rd_idx), 0);
      chk("rst.res_valid", int'(res_valid), 0);
      chk("rst.res_equal", int'(res_equal), 0);
      chk("rst.res_a_larger", int'(res_a_larger), 0);
      chk("rst.res_diff", int'(res_diff), 0);
      chk("rst.res_used", int'(res_bytes_used), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.start_ready", int'(start_ready), 1);

      // directed table
      for (int i = 0; i < 9; i++) begin
         v = vecs[i];
         run_op($sformatf("vec%0d", i), v.len, v.sgn, v.a, v.b, v.gap, 0, 1'b0,
                v.eq, v.gt, v.diff, v.used);
      end

      // result held under back-pressure, start ignored while busy
      run_op("hold5", 2, 1'b0, 32'h0000_1234, 32'h0000_1230, 0, 5, 1'b1,
             1'b0, 1'b1, 'h04, 2);

      // reset while fetching index 1
      @(negedge clk);
      start_valid = 1'b1; len = 3'd3; signed_mode = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      chk("rstf.idx2", int'(rd_idx), 2);
      rd_valid = 1'b1; rd_a = 8'h5A; rd_b = 8'h5A;
      @(negedge clk);
      rd_valid = 1'b0;
      chk("rstf.idx1", int'(rd_idx), 1);
      chk("rstf.req", int'(rd_req), 1);
      rst = 1'b1;
      #1;
      chk("rstf.async_req", int'(rd_req), 0);
      chk("rstf.async_idx", int'(rd_idx), 0);
      chk("rstf.async_valid", int'(res_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rstf.no_result", int'(res_valid), 0);
         chk("rstf.no_fetch", int'(rd_req), 0);
         chk("rstf.idle", int'(start_ready), 1);
      end

      // randomized ops against the reference model
      for (int t = 0; t < 40; t++) begin
         int          l = $urandom_range(0, 6);
         bit          sgn = 1'($urandom_range(0, 1));
         logic [31:0] a = $urandom;
         logic [31:0] b = a;
         int          sel = $urandom_range(0, 4);
         if (sel < 4) b[sel*8 +: 8] = 8'($urandom);
         model(l, sgn, a, b, m_eq, m_gt, m_diff, m_used);
         run_op($sformatf("rnd%0d", t), l, sgn, a, b, $urandom_range(0, 2),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                m_eq, m_gt, m_diff, m_used);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multibyte_compare_ctrl.md
MULTIBYTE_COMPARE_CTRL -- requirements
Module: multibyte_compare_ctrl

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8, giving the width of each operand byte.
REQ-002 SHALL have parameter MAX_BYTES, default 4, giving the maximum operand length in bytes (>=1).
REQ-003 SHALL derive IW = max(1, clog2(MAX_BYTES)) and LW = clog2(MAX_BYTES+1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start_valid  in  1  request to begin a comparison.
REQ-007 start_ready  out  1  block can accept a start.
REQ-008 len  in  LW  operand length in bytes; sampled on start handshake.
REQ-009 signed_mode  in  1  1 = two's-complement operands; sampled on start handshake.
REQ-010 rd_req  out  1  byte fetch request.
REQ-011 rd_idx  out  IW  byte index requested; MSB byte = len-1.
REQ-012 rd_valid  in  1  rd_a/rd_b valid for current rd_idx.
REQ-013 rd_a, rd_b  in  BYTE_WIDTH each  operand bytes.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  consumer accepts result.
REQ-016 res_equal, res_a_larger  out  1 each  final relation; never both 1.
REQ-017 res_diff  out  BYTE_WIDTH  XOR of the deciding byte pair (0 when equal).
REQ-018 res_bytes_used  out  LW  number of byte pairs consumed.

Function
REQ-019 SHALL implement states IDLE, FETCH, DONE; start_ready = 1 only in IDLE.
REQ-020 Start handshake (start_valid & start_ready) in IDLE with 1<=len<=MAX_BYTES SHALL latch len and signed_mode and enter FETCH next cycle with rd_idx = len-1.
REQ-021 len > MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-022 len = 0 SHALL go directly to DONE with res_equal=1, res_a_larger=0, res_diff=0, res_bytes_used=0, no rd_req.
REQ-023 In FETCH, rd_req SHALL be 1 and rd_idx stable until rd_valid is sampled high; wait cycles unbounded.
REQ-024 Per accepted byte, comparison SHALL be MSB-first within the byte; byte equal iff rd_a==rd_b; a_larger decided at highest differing bit.
REQ-025 When signed_mode=1, the byte at index len-1 SHALL be compared with its top bit inverted on both operands; other bytes unsigned.
REQ-026 On accepted byte with rd_a!=rd_b: next cycle DONE, res_equal=0, res_a_larger per REQ-024/025, res_diff=rd_a^rd_b (uninverted), res_bytes_used = bytes consumed including this one.
REQ-027 On accepted equal byte with rd_idx=0: next cycle DONE, res_equal=1, res_bytes_used=len.
REQ-028 On accepted equal byte with rd_idx>0: stay FETCH, rd_idx decrements by 1 next cycle (early termination; no wrap below 0).
REQ-029 rd_valid outside FETCH SHALL be ignored.
REQ-030 In DONE, res_valid=1 and all res_* outputs SHALL hold until res_valid & res_ready; next cycle IDLE, res_valid=0.
REQ-031 start_valid while not IDLE SHALL be ignored (not queued).
REQ-032 Minimum latency start handshake to res_valid: 2 cycles for one-byte decision; N+1 cycles for N back-to-back rd_valid bytes.

Reset
REQ-033 rst SHALL asynchronously force IDLE, start_ready=1 after release, rd_req=0, rd_idx=0, res_valid=0, res_equal=0, res_a_larger=0, res_diff=0, res_bytes_used=0.
REQ-034 rst mid-FETCH or mid-DONE SHALL discard the operation; no result is produced afterwards.

Verification
REQ-035 len=2, unsigned, bytes idx1 (0x12,0x12), idx0 (0x34,0x30) -> res_equal=0, res_a_larger=1, res_diff=0x04, res_bytes_used=2.
REQ-036 len=4, unsigned, idx3 (0x01,0x02) -> DONE after 1 byte, res_a_larger=0, res_diff=0x03, res_bytes_used=1, rd_idx never reaches 2.
REQ-037 len=1, signed, (0x80,0x7F) -> res_a_larger=0; same bytes unsigned -> res_a_larger=1.
REQ-038 len=3, all bytes 0xAA/0xAA with 2-cycle rd_valid gaps -> res_equal=1, res_diff=0, res_bytes_used=3; rd_idx holds during gaps.
REQ-039 len=0 and len=7 (MAX_BYTES=4) -> immediate equal with 0 bytes; clamped 4 fetches starting rd_idx=3.
REQ-040 rst asserted while in FETCH at rd_idx=1, res_ready held low in DONE for 5 cycles -> immediate IDLE, no res_valid; held outputs stable all 5 cycles.
